// File: rtl/stackseq_pkg.sv
// ============================================================================
// Module  : stackseq_pkg
// Brief   : Shared types, io_in bit positions and helpers for the stack-calc
//           sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package stackseq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    RESP   = 3'd4
  } stackseq_state_e;

  localparam int CALC_CLK_BIT   = 0;
  localparam int MODE2_BIT      = 1;
  localparam int DATA_LSB       = 2;
  localparam int MODE_LSB       = 6;
  localparam int CMD_FIFO_DEPTH = 4;

  typedef struct packed {
    logic       capture;
    logic [2:0] mode;
    logic [3:0] data;
  } stackseq_cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Core io_in image for a command with the calculator clock low.
  function automatic logic [7:0] pack_fields(input logic [2:0] mode, input logic [3:0] data);
    logic [7:0] f;
    f                  = '0;
    f[MODE_LSB +: 2]   = mode[1:0];
    f[DATA_LSB +: 4]   = data;
    f[MODE2_BIT]       = mode[2];
    f[CALC_CLK_BIT]    = 1'b0;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stackcalc_sequencer_if.sv
// ============================================================================
// Module  : stackcalc_sequencer_if
// Brief   : Command and response handshake bundle of the stack-calc sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface stackcalc_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_data;
  logic       cmd_capture;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_mode, cmd_data, cmd_capture, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_data, cmd_capture, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

`default_nettype wire

// File: rtl/stackseq_fifo.sv
// ============================================================================
// Module  : stackseq_fifo
// Brief   : Parameterised synchronous FIFO with asynchronous active-low reset.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module stackseq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   C_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == C_FULL);
  assign empty   = (r_count == '0);
  // A push while full is refused even if a pop frees a slot this same cycle.
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/stackcalc_sequencer.sv
// ============================================================================
// Module  : stackcalc_sequencer
// Brief   : Drives the stack-calculator io_in bus from command words, generating
//           the slow calc clock on io_in[0]. STACKSEQ_FIFO_EN adds a 4-deep
//           command FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module stackcalc_sequencer
  import stackseq_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  stackcalc_sequencer_if.slave  bus,
  output logic [7:0]            calc_in,
  input  logic [7:0]            calc_out,
  output logic                  busy,
  output logic [15:0]           instr_count
);

  localparam int                CNT_W        = $clog2(max_int(SETUP_CYCLES, PULSE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0]  C_SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);

  stackseq_state_e  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_calc_in;
  logic             r_capture;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;
  logic [15:0]      r_instr_count;

  stackseq_cmd_t    w_next_cmd;
  logic             w_cmd_take;

`ifdef STACKSEQ_FIFO_EN
  stackseq_cmd_t    w_cmd_in;
  logic [7:0]       w_fifo_q;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  assign w_cmd_in      = '{capture: bus.cmd_capture, mode: bus.cmd_mode, data: bus.cmd_data};
  assign bus.cmd_ready = !w_fifo_full;
  assign w_cmd_take    = (r_state == IDLE) && !w_fifo_empty;
  assign w_next_cmd    = stackseq_cmd_t'(w_fifo_q);

  stackseq_fifo #(
    .WIDTH ($bits(stackseq_cmd_t)),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.cmd_valid),
    .wr_data (w_cmd_in),
    .pop     (w_cmd_take),
    .rd_data (w_fifo_q),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );
`else
  assign bus.cmd_ready = (r_state == IDLE);
  assign w_cmd_take    = (r_state == IDLE) && bus.cmd_valid;
  assign w_next_cmd    = '{capture: bus.cmd_capture, mode: bus.cmd_mode, data: bus.cmd_data};
`endif

  assign calc_in       = r_calc_in;
  assign busy          = (r_state != IDLE);
  assign instr_count   = r_instr_count;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

  // Fields only change on IDLE->SETUP, so they are always settled before the
  // calc clock rises and held through its fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_calc_in     <= '0;
      r_capture     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_take) begin
            r_calc_in <= pack_fields(w_next_cmd.mode, w_next_cmd.data);
            r_capture <= w_next_cmd.capture;
            r_cnt     <= C_SETUP_LOAD;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_calc_in[CALC_CLK_BIT] <= 1'b1;
            r_cnt                   <= C_PULSE_LOAD;
            r_state                 <= CLK_HI;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        CLK_HI: begin
          if (r_cnt == '0) begin
            r_calc_in[CALC_CLK_BIT] <= 1'b0;
            r_cnt                   <= C_PULSE_LOAD;
            r_state                 <= CLK_LO;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        CLK_LO: begin
          if (r_cnt == '0) begin
            r_instr_count <= r_instr_count + 16'd1;
            if (r_capture) begin
              r_rsp_data  <= calc_out;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stackcalc_sequencer.sv
// ============================================================================
// Module  : tb_stackcalc_sequencer
// Brief   : Self-checking bench: vector table, response scoreboard and
//           hand-written multi-cycle sequences for the stack-calc sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stackcalc_sequencer;

`ifdef STACKSEQ_FIFO_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  calc_in;
  logic [7:0]  calc_out;
  logic        busy;
  logic [15:0] instr_count;
  logic [7:0]  key;

  stackcalc_sequencer_if bus ();

  stackcalc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .calc_in     (calc_in),
    .calc_out    (calc_out),
    .busy        (busy),
    .instr_count (instr_count)
  );

  // Core stand-in: output depends on io_in and the calc clock level, so a
  // capture taken in the wrong phase gives a different byte.
  assign calc_out = (calc_in[0] ? 8'h00 : calc_in) ^ key;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] data;
    logic       cap;
    logic [7:0] key;
    logic [7:0] exp_ci;
  } vec_t;

  vec_t        vecs [6];
  logic [7:0]  exp_q [$];
  logic [7:0]  wave_ci [5];
  logic        wave_rv [5];
  logic [7:0]  mon_exp;
  logic [15:0] exp_count;
  int          n_checks;
  int          n_pass;
  int          cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic logic [7:0] fields(input logic [2:0] m, input logic [3:0] d);
    return {m[1:0], d, m[2], 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] m, input logic [3:0] d, input logic c, input logic expect_rsp);
    bus.cmd_mode    = m;
    bus.cmd_data    = d;
    bus.cmd_capture = c;
    bus.cmd_valid   = 1'b1;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    if (c && expect_rsp) exp_q.push_back(fields(m, d) ^ key);
    exp_count++;
    step();
    bus.cmd_valid = 1'b0;
    repeat (EXTRA) step();
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 100 && busy; i++) step();
    check(name, busy, 0);
  endtask

  // Scoreboard: compare at the negedge preceding each response handshake edge.
  always @(negedge clk) begin
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: got %02h, required no response", bus.rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; exp_count = 0; key = 8'h00;
    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_data = '0;
    bus.cmd_capture = 1'b0; bus.rsp_ready = 1'b0;

    vecs[0] = '{mode: 3'd0, data: 4'h0, cap: 1'b1, key: 8'hA5, exp_ci: 8'h00};
    vecs[1] = '{mode: 3'd7, data: 4'hF, cap: 1'b1, key: 8'h5A, exp_ci: 8'hFE};
    vecs[2] = '{mode: 3'd2, data: 4'h3, cap: 1'b0, key: 8'h11, exp_ci: 8'h8C};
    vecs[3] = '{mode: 3'd4, data: 4'h8, cap: 1'b1, key: 8'hFF, exp_ci: 8'h22};
    vecs[4] = '{mode: 3'd1, data: 4'h6, cap: 1'b1, key: 8'h00, exp_ci: 8'h58};
    vecs[5] = '{mode: 3'd6, data: 4'h1, cap: 1'b1, key: 8'h81, exp_ci: 8'h86};
    wave_ci = '{8'h6B, 8'h6B, 8'h6A, 8'h6A, 8'h6A};
    wave_rv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) step();
    check("rst_calc_in", calc_in, 8'h00);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_instr_count", instr_count, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    rst = 1'b1;
    step();

    // Single captured command: field image, calc clock waveform, latency
    key = 8'h3C;
    issue(3'b101, 4'hA, 1'b1, 1'b1);
    check("load_calc_in", calc_in, 8'h6A);
    check("load_busy", busy, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("wave_calc_in", calc_in, wave_ci[k]);
      check("wave_rsp_valid", bus.rsp_valid, wave_rv[k]);
    end
    check("first_rsp_data", bus.rsp_data, 8'h56);
    check("first_instr_count", instr_count, exp_count);

    // Backpressure: response and bus frozen for 20 cycles
    key = 8'hFF;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.rsp_valid && bus.rsp_data == 8'h56 && !calc_in[0]) cnt++;
    end
    check("bp_stable_cycles", cnt, 20);
    bus.rsp_ready = 1'b1;
    step();
    check("bp_rsp_cleared", bus.rsp_valid, 0);
    check("bp_busy_cleared", busy, 0);

    // Capture=0 command: no response, busy low by 6 cycles after acceptance
    issue(3'd2, 4'h3, 1'b0, 1'b0);
    cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (bus.rsp_valid) cnt++;
      if (k == 5) check("nocap_count", instr_count, exp_count);
    end
    check("nocap_busy", busy, 0);
    check("nocap_no_rsp", cnt, 0);

`ifndef STACKSEQ_FIFO_EN
    // Back-to-back non-capture commands: exactly one IDLE cycle between
    bus.cmd_mode = 3'd0; bus.cmd_data = 4'h1; bus.cmd_capture = 1'b0; bus.cmd_valid = 1'b1;
    step();
    bus.cmd_mode = 3'd3; bus.cmd_data = 4'h2;
    cnt = 0;
    while (!bus.cmd_ready && cnt < 20) begin
      step();
      cnt++;
    end
    check("b2b_gap", cnt, 5);
    step();
    bus.cmd_valid = 1'b0;
    check("b2b_second_fields", calc_in, 8'hC8);
    exp_count += 2;
    wait_idle("b2b_idle");
    check("b2b_count", instr_count, exp_count);
`endif

    // Vector table
    for (int i = 0; i < 6; i++) begin
      key = vecs[i].key;
      issue(vecs[i].mode, vecs[i].data, vecs[i].cap, 1'b1);
      check("vec_calc_in", calc_in, vecs[i].exp_ci);
      wait_idle("vec_idle");
    end
    check("vec_count", instr_count, exp_count);
    check("vec_drained", exp_q.size(), 0);

    // Reset during CLK_HI
    key = 8'h77;
    issue(3'd7, 4'h5, 1'b1, 1'b0);
    step();
    check("midrst_clk_high", calc_in[0], 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_calc_in", calc_in, 8'h00);
    check("midrst_busy", busy, 0);
    exp_count = 0;
    step();
    step();
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.rsp_valid) cnt++;
    end
    check("midrst_no_rsp", cnt, 0);
    check("midrst_count", instr_count, 0);

`ifdef STACKSEQ_FIFO_EN
    // FIFO fill while the sequencer is stalled on a response
    bus.rsp_ready = 1'b0;
    key = 8'h5A;
    issue(3'd1, 4'h1, 1'b1, 1'b1);
    for (int k = 0; k < 20 && !bus.rsp_valid; k++) step();
    check("fifo_stalled", bus.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      bus.cmd_mode = 3'(i + 2); bus.cmd_data = 4'(i * 3); bus.cmd_capture = 1'b1; bus.cmd_valid = 1'b1;
      if (i < 4) begin
        check("fifo_ready", bus.cmd_ready, 1);
        exp_q.push_back(fields(3'(i + 2), 4'(i * 3)) ^ key);
        exp_count++;
      end else begin
        check("fifo_full_ready", bus.cmd_ready, 0);
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (60) step();
    check("fifo_drained", exp_q.size(), 0);
    check("fifo_count", instr_count, exp_count);
`endif

    // instr_count wrap
    force dut.r_instr_count = 16'hFFFF;
    step();
    release dut.r_instr_count;
    step();
    check("wrap_preload", instr_count, 16'hFFFF);
    issue(3'd0, 4'h0, 1'b0, 1'b0);
    wait_idle("wrap_idle");
    check("wrap_count", instr_count, 16'h0000);

    check("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
